spi_master_ctrl: RTL and testbench



---
 rtl/spi_master_ctrl_if.sv | 22 ++
 rtl/spi_master_ctrl.sv | 148 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Command/response handshake bundle for spi_master_ctrl.
// master: host issuing commands; slave: the SPI initiator serving them.
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI initiator for the modulator's 34-bit register-access frame.
// Ports: clk, rst_n, bus (cmd/rsp), SCLK/MOSI/CSN out, MISO/MISO_enable in.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_ctrl_if.slave bus,
  output logic             SCLK,
  output logic             MOSI,
  output logic             CSN,
  input  logic             MISO,
  input  logic             MISO_enable
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;
  state_t state, state_n;

  logic [HW-1:0] hcnt;
  logic [5:0]    bcnt;
  logic [33:0]   sh;
  logic          rw_q;
  logic [7:0]    racc;
  logic          eacc;
  logic          rv_q;
  logic [7:0]    rd_q;
  logic          err_q;

  logic ph_end;
  logic accept;
  logic start;
  logic rise;
  logic fall;
  logic fend;
  logic gstep;

  assign ph_end = (hcnt == HLAST);
  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rd_q;
  assign bus.rsp_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // CSN still high in FRAME marks the first cycle after accept.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    start   = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    fend    = 1'b0;
    gstep   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_n = FRAME;
        end
      end
      FRAME: begin
        if (CSN) begin
          start = 1'b1;
        end else if (ph_end) begin
          if (!SCLK) begin
            rise = 1'b1;
          end else if (bcnt == 6'd33) begin
            fend    = 1'b1;
            state_n = GAP;
          end else begin
            fall = 1'b1;
          end
        end
      end
      GAP: begin
        if (ph_end) begin
          gstep = 1'b1;
          if (bcnt == 6'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt  <= '0;
      bcnt  <= '0;
      sh    <= '0;
      rw_q  <= 1'b0;
      racc  <= '0;
      eacc  <= 1'b0;
      SCLK  <= 1'b0;
      MOSI  <= 1'b0;
      CSN   <= 1'b1;
      rv_q  <= 1'b0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (accept) begin
        sh <= {bus.cmd_rw, bus.cmd_addr, 9'b0,
               bus.cmd_rw ? bus.cmd_wdata : 8'h00, 6'b0};
        rw_q <= bus.cmd_rw;
        racc <= '0;
        eacc <= 1'b0;
      end
      if (start) begin
        hcnt <= '0;
        bcnt <= '0;
        CSN  <= 1'b0;
        MOSI <= sh[33];
      end else if (state != IDLE) begin
        hcnt <= ph_end ? '0 : hcnt + 1'b1;
      end
      // Data bits 21..28 are sampled as SCLK rises.
      if (rise) begin
        SCLK <= 1'b1;
        if (!rw_q && bcnt >= 6'd21 && bcnt <= 6'd28) begin
          racc <= {racc[6:0], MISO & MISO_enable};
          eacc <= eacc | ~MISO_enable;
        end
      end
      if (fall) begin
        SCLK <= 1'b0;
        MOSI <= sh[32];
        sh   <= {sh[32:0], 1'b0};
        bcnt <= bcnt + 6'd1;
      end
      // bcnt is reused to count the two half-periods of GAP.
      if (fend) begin
        SCLK  <= 1'b0;
        CSN   <= 1'b1;
        MOSI  <= 1'b0;
        bcnt  <= '0;
        rv_q  <= 1'b1;
        rd_q  <= racc;
        err_q <= eacc;
      end
      if (gstep) bcnt <= bcnt + 6'd1;
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: CLK_DIV 4/2/1 instances, timing model + responder.
// Directed frames, back-to-back, reset abort and a 256-register sweep.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
  logic tb_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic       cv = 1'b0;
  logic       c_rw = 1'b0;
  logic [9:0] c_addr = '0;
  logic [7:0] c_wd = '0;
  logic       miso = 1'b1;
  logic       miso_en = 1'b1;
  int         sel = 0;

  logic s4, m4, c4, s2, m2, c2, s1, m1, c1;

  spi_master_ctrl_if b4();
  spi_master_ctrl_if b2();
  spi_master_ctrl_if b1();

  assign b4.cmd_valid = cv && (sel == 0);
  assign b2.cmd_valid = cv && (sel == 1);
  assign b1.cmd_valid = cv && (sel == 2);
  assign b4.cmd_rw = c_rw;
  assign b2.cmd_rw = c_rw;
  assign b1.cmd_rw = c_rw;
  assign b4.cmd_addr = c_addr;
  assign b2.cmd_addr = c_addr;
  assign b1.cmd_addr = c_addr;
  assign b4.cmd_wdata = c_wd;
  assign b2.cmd_wdata = c_wd;
  assign b1.cmd_wdata = c_wd;

  spi_master_ctrl #(.CLK_DIV(4)) u4 (
    .clk(tb_clk), .rst_n(rst_n), .bus(b4),
    .SCLK(s4), .MOSI(m4), .CSN(c4),
    .MISO(miso), .MISO_enable(miso_en));
  spi_master_ctrl #(.CLK_DIV(2)) u2 (
    .clk(tb_clk), .rst_n(rst_n), .bus(b2),
    .SCLK(s2), .MOSI(m2), .CSN(c2),
    .MISO(miso), .MISO_enable(miso_en));
  spi_master_ctrl #(.CLK_DIV(1)) u1 (
    .clk(tb_clk), .rst_n(rst_n), .bus(b1),
    .SCLK(s1), .MOSI(m1), .CSN(c1),
    .MISO(miso), .MISO_enable(miso_en));

  logic sclk, mosi, csn, rdy, rv, rerr;
  logic [7:0] rrd;

  always_comb begin
    case (sel)
      0: begin
        sclk = s4; mosi = m4; csn = c4; rdy = b4.cmd_ready;
        rv = b4.rsp_valid; rrd = b4.rsp_rdata; rerr = b4.rsp_err;
      end
      1: begin
        sclk = s2; mosi = m2; csn = c2; rdy = b2.cmd_ready;
        rv = b2.rsp_valid; rrd = b2.rsp_rdata; rerr = b2.rsp_err;
      end
      default: begin
        sclk = s1; mosi = m1; csn = c1; rdy = b1.cmd_ready;
        rv = b1.rsp_valid; rrd = b1.rsp_rdata; rerr = b1.rsp_err;
      end
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [33:0] act,
                     input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @%0t: timed out", nm, $time);
  endtask

  function automatic int dv(input int s);
    return (s == 0) ? 4 : ((s == 1) ? 2 : 1);
  endfunction

  // Responder: register file or fixed byte, with per-bit enable mask.
  logic       rf_mode = 1'b0;
  logic [7:0] resp_byte = '0;
  logic [7:0] en_mask = 8'hFF;
  logic [7:0] rf [256];
  int         rcnt = 0;
  logic [33:0] rx = '0;
  logic [9:0] raddr = '0;
  logic       ps = 1'b0;
  logic       pc = 1'b1;
  logic [7:0] bv;

  initial for (int i = 0; i < 256; i++) rf[i] = 8'h00;

  always @(sclk or csn) begin
    if (pc && !csn) begin
      rcnt = 0;
      rx = '0;
      miso = 1'b1;
      miso_en = 1'b1;
    end
    if (!pc && csn && rcnt == 34 && rx[33])
      rf[rx[30:23]] = rx[13:6];
    if (!csn && sclk && !ps) begin
      rx = {rx[32:0], mosi};
      rcnt++;
    end
    if (!csn && !sclk && ps) begin
      if (rcnt == 11) raddr = rx[9:0];
      if (rcnt >= 21 && rcnt <= 28) begin
        bv = rf_mode ? rf[raddr[7:0]] : resp_byte;
        miso = bv[28 - rcnt];
        miso_en = en_mask[28 - rcnt];
      end else begin
        miso = 1'b1;
        miso_en = 1'b1;
      end
    end
    ps = sclk;
    pc = csn;
  end

  // Timing model: all expectations derived from T0 and CLK_DIV.
  int n_rsp = 0;
  int last_len = 0;
  int last_fall = 0;
  int prev_fall = 0;
  logic [7:0] mem [256];

  initial begin : cmp
    int cyc, t0, d, rel, idx, lowrun;
    bit busy;
    logic [33:0] fb;
    logic [7:0] xrd;
    logic xerr, pcsn, e_csn, e_sclk, e_rdy, e_rv;
    logic [7:0] hrd [3];
    logic herr [3];
    cyc = 0; t0 = 0; lowrun = 0; busy = 0; pcsn = 1'b1;
    fb = '0; xrd = '0; xerr = 1'b0;
    for (int i = 0; i < 3; i++) begin hrd[i] = '0; herr[i] = 1'b0; end
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(negedge tb_clk);
      cyc++;
      d = dv(sel);
      if (!rst_n) begin
        busy = 0;
        lowrun = 0;
        for (int i = 0; i < 3; i++) begin hrd[i] = '0; herr[i] = 1'b0; end
        chk("rst_csn", csn, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ready", rdy, 1);
        chk("rst_rsp_valid", rv, 0);
        chk("rst_rdata", rrd, 0);
        chk("rst_err", rerr, 0);
      end else begin
        e_csn = 1'b1; e_sclk = 1'b0; e_rdy = 1'b0; e_rv = 1'b0;
        if (busy && cyc >= t0 + 70 * d) busy = 0;
        if (!busy) begin
          e_rdy = 1'b1;
          if (cv) begin
            busy = 1;
            t0 = cyc + 2;
            fb = {c_rw, c_addr, 9'b0, c_rw ? c_wd : 8'h00, 6'b0};
            if (c_rw) begin
              xrd = 8'h00; xerr = 1'b0;
              if (rf_mode) mem[c_addr[7:0]] = c_wd;
            end else if (rf_mode) begin
              xrd = mem[c_addr[7:0]]; xerr = 1'b0;
            end else begin
              xrd = resp_byte & en_mask; xerr = (en_mask != 8'hFF);
            end
          end
        end else begin
          rel = cyc - t0;
          if (rel >= 0 && rel < 68 * d) begin
            e_csn = 1'b0;
            e_sclk = ((rel / d) % 2) == 1;
            idx = 33 - rel / (2 * d);
            chk("mosi", mosi, fb[idx]);
          end
          if (rel == 68 * d) begin
            e_rv = 1'b1;
            hrd[sel] = xrd;
            herr[sel] = xerr;
          end
        end
        chk("csn", csn, e_csn);
        chk("sclk", sclk, e_sclk);
        chk("cmd_ready", rdy, e_rdy);
        chk("rsp_valid", rv, e_rv);
        chk("rsp_rdata", rrd, hrd[sel]);
        chk("rsp_err", rerr, herr[sel]);
        if (rv) n_rsp++;
        if (!csn) begin
          lowrun++;
        end else if (lowrun > 0) begin
          chk("csn_low_len", lowrun, 68 * d);
          last_len = lowrun;
          lowrun = 0;
        end
        if (pcsn && !csn) begin
          prev_fall = last_fall;
          last_fall = cyc;
        end
      end
      pcsn = csn;
    end
  end

  task automatic send(input logic rw, input logic [9:0] a,
                      input logic [7:0] wd, input bit keep);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    @(posedge tb_clk); #1;
    cv = 1'b1; c_rw = rw; c_addr = a; c_wd = wd;
    while (!ok && n < 2000) begin
      @(negedge tb_clk);
      if (rdy) ok = 1;
      n++;
    end
    if (!ok) timeout("accept");
    @(posedge tb_clk); #1;
    if (!keep) cv = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    bit ok;
    n = 0;
    ok = 0;
    while (!ok && n < 2000) begin
      @(negedge tb_clk);
      if (rv) ok = 1;
      n++;
    end
    if (!ok) timeout("rsp");
    #2;
  endtask

  initial begin : stim
    int nr, n;
    bit ok;
    logic [33:0] ef;
    logic [7:0] ed;
    repeat (3) @(posedge tb_clk);
    #1 rst_n = 1'b1;
    @(negedge tb_clk);
    chk("init_ready", rdy, 1);
    chk("init_csn", csn, 1);
    chk("init_sclk", sclk, 0);
    chk("init_rsp_valid", rv, 0);

    // Write 0x2A5 <= 0xC3 at CLK_DIV 4
    send(1'b1, 10'h2A5, 8'hC3, 0);
    wait_rsp();
    ef = {1'b1, 10'h2A5, 9'h0, 8'hC3, 6'h0};
    chk("wr_mosi_frame", rx, ef);
    chk("wr_rises", rcnt, 34);
    chk("wr_csn_low_272", last_len, 272);
    chk("wr_rdata", rrd, 8'h00);
    chk("wr_err", rerr, 0);
    repeat (12) @(posedge tb_clk);
    chk("wr_one_pulse", n_rsp, 1);

    // Read 0x013, responder returns 0x5A
    resp_byte = 8'h5A;
    en_mask = 8'hFF;
    send(1'b0, 10'h013, 8'hFF, 0);
    wait_rsp();
    chk("rd_rdata_5A", rrd, 8'h5A);
    chk("rd_err", rerr, 0);
    chk("rd_mosi_data0", rx[12:5], 8'h00);
    ef = {1'b0, 10'h013, 23'h0};
    chk("rd_mosi_frame", rx, ef);

    // MISO_enable low on bit 24
    resp_byte = 8'hFF;
    en_mask = 8'hEF;
    send(1'b0, 10'h100, 8'h00, 0);
    wait_rsp();
    chk("rd_en_rdata_EF", rrd, 8'hEF);
    chk("rd_en_err", rerr, 1);
    en_mask = 8'hFF;
    repeat (12) @(posedge tb_clk);

    // Back-to-back at CLK_DIV 2
    @(posedge tb_clk); #1 sel = 1;
    resp_byte = 8'h3C;
    nr = n_rsp;
    send(1'b1, 10'h155, 8'h99, 1);
    send(1'b0, 10'h0AA, 8'h00, 0);
    wait_rsp();
    chk("b2b_pitch_142", last_fall - prev_fall, 142);
    chk("b2b_rdata", rrd, 8'h3C);
    chk("b2b_pulses", n_rsp - nr, 2);
    repeat (8) @(posedge tb_clk);

    // Reset during address bit 5 at CLK_DIV 4
    @(posedge tb_clk); #1 sel = 0;
    send(1'b1, 10'h3C3, 8'h11, 0);
    n = 0;
    ok = 0;
    while (!ok && n < 500) begin
      @(negedge tb_clk);
      if (rcnt == 6) ok = 1;
      n++;
    end
    if (!ok) timeout("reach_bit5");
    @(posedge tb_clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_csn", csn, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_mosi", mosi, 0);
    nr = n_rsp;
    repeat (3) @(posedge tb_clk);
    #1 rst_n = 1'b1;
    repeat (300) @(posedge tb_clk);
    chk("abort_no_rsp", n_rsp - nr, 0);
    @(negedge tb_clk);
    chk("abort_ready", rdy, 1);
    send(1'b1, 10'h0FF, 8'hA5, 0);
    wait_rsp();
    ef = {1'b1, 10'h0FF, 9'h0, 8'hA5, 6'h0};
    chk("post_rst_frame", rx, ef);
    chk("post_rst_rdata", rrd, 8'h00);
    repeat (12) @(posedge tb_clk);

    // 256-register sweep at CLK_DIV 1
    @(posedge tb_clk); #1 sel = 2; rf_mode = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ed = 8'((i * 37 + 11) & 255);
      send(1'b1, 10'(i), ed, 0);
    end
    for (int i = 0; i < 256; i++) send(1'b0, 10'(i), 8'h00, 0);
    wait_rsp();
    ed = 8'((255 * 37 + 11) & 255);
    chk("rf_last_rdata", rrd, ed);
    chk("rf_last_err", rerr, 0);
    chk("rf_csn_low_68", last_len, 68);
    repeat (10) @(posedge tb_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
